fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage with IF/ID pipeline register, directly upstream of the decode stage whose opcode drives the main decoder. Holds the PC and issues instruction-memory requests under a ready handshake. Delivers instr_d/pcplus4_d/valid_d to decode. Honours hazard stalls without losing fetched words, and accepts branch/jump redirects from decode, flushing the wrong-path slot.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
imem_addr  output  32  fetch address; always equals pc_f
imem_req  output  1  fetch request
imem_rdata  input  32  instruction word; valid in the cycle imem_ready=1
imem_ready  input  1  fetch completes in cycles where imem_req && imem_ready
stall_d  input  1  hazard unit: hold IF/ID and PC
redirect_valid  input  1  one-cycle pulse from decode: taken branch/J/JAL
redirect_target  input  32  new PC; bits [1:0] ignored, forced to 00
instr_d  output  32  IF/ID instruction to decoder
pcplus4_d  output  32  IF/ID PC+4 (branch base / JAL link value)
valid_d  output  1  IF/ID slot holds a real instruction

Behaviour:
- Reset (async, reset_n low): pc_f=RESET_PC, instr_d=32'h0, pcplus4_d=0, valid_d=0, state=RUN, hold_instr=0, redir_pc=0. imem_req=0 while reset_n is low.
- Handshake: while imem_req && !imem_ready, imem_addr must remain stable. No new address is issued until the outstanding request completes.
- Flush: instr_d<=32'h0 (sll $0: harmless R-type), pcplus4_d<=0, valid_d<=0.
- Advance (from word W): instr_d<=W, pcplus4_d<=pc_f+4, valid_d<=1, pc_f<=pc_f+4. All adds are modulo 2^32, so 0xFFFF_FFFC+4 wraps to 0.
- FSM states: RUN, HOLD, DRAIN. imem_req=1 in RUN and DRAIN, 0 in HOLD.
- RUN, evaluated in priority order:
  - redirect && ready: pc_f<=target, flush, stay RUN.
  - redirect && !ready: redir_pc<=target, flush, go DRAIN.
  - ready && !stall_d: advance with imem_rdata.
  - ready && stall_d: hold_instr<=imem_rdata, IF/ID and pc_f unchanged, go HOLD.
  - otherwise (!ready): IF/ID and pc_f unchanged.
- HOLD:
  - redirect: pc_f<=target, flush, discard hold_instr, go RUN.
  - else !stall_d: advance with hold_instr, go RUN.
  - else: stay.
- DRAIN (wrong-path request still outstanding; imem_addr = old pc_f):
  - Data returned here is discarded and valid_d stays 0. stall_d is ignored because the slot is a bubble.
  - A redirect in DRAIN overwrites redir_pc; the latest redirect wins.
  - On ready: pc_f<=(redirect ? target : redir_pc), go RUN.
- redirect_valid overrides stall_d in every state.
- Latency: 1 cycle from imem_ready (unstalled) to instr_d valid. Redirect to new imem_addr takes 1 cycle, or the drain time plus 1 cycle.
- Sustained throughput: 1 instruction per cycle when imem_ready=1 and stall_d=0.

Decomposition:
- Shared package fetch_pkg:
  - typedef enum logic [1:0] fetch_state_t {RUN, HOLD, DRAIN}
  - NOP_INSTR = 32'h0000_0000
  - RESET_PC_DEFAULT
- Sub-module if_id_reg: async active-low reset, en and flush inputs; flush takes precedence over en. Holds instr_d, pcplus4_d, valid_d. fetch_stage contains the FSM, pc_f, hold_instr and redir_pc.

Test Plan:
1. Release reset with imem_ready=1, stall_d=0, memory returning addr+0x100. Required: imem_addr 0,4,8 on consecutive cycles; instr_d 0x100,0x104 with pcplus4_d 4,8; valid_d first high one cycle after the first completion.
2. Hold imem_ready=0 for 3 cycles at addr 0x8. Required: imem_addr stays 0x8 and IF/ID is unchanged; on ready, instr_d=0x108 and pcplus4_d=0xC.
3. Assert stall_d for 2 cycles while word 0x10C returns at 0xC. Required: HOLD entered, imem_req=0 and pc_f=0xC held; after release, instr_d=0x10C, pcplus4_d=0x10, next imem_addr=0x10.
4. redirect_valid with target 0x43 while ready=1 at 0x14. Required: next imem_addr=0x40, valid_d=0, instr_d=0; the following word appears with pcplus4_d=0x44.
5. Redirect to 0x40 while waiting at 0x10, then redirect to 0x80 two cycles later, then ready. Required: imem_addr stays 0x10 throughout, wrong-path data dropped, next imem_addr=0x80, valid_d=0 throughout.
6. Pull reset_n low mid-DRAIN, between clock edges. Required: imem_req=0, valid_d=0, imem_addr=RESET_PC immediately. After release, fetch restarts at RESET_PC with no trace of the old redirect.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // IF/ID payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
  } ifid_t;

  // Word-align a PC; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~XLEN'(32'h3);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register; flush wins over enable and inserts a NOP bubble.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            flush,
  input  ifid_t           d,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_d   <= NOP_INSTR;
      pcplus4_d <= '0;
      valid_d   <= 1'b0;
    end else if (flush) begin
      instr_d   <= NOP_INSTR;
      pcplus4_d <= '0;
      valid_d   <= 1'b0;
    end else if (en) begin
      instr_d   <= d.instr;
      pcplus4_d <= d.pcplus4;
      valid_d   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem handshake, stall holding and redirect draining,
// feeding the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
);

  fetch_state_t    state_q, state_n;
  logic [XLEN-1:0] pc_f, pc_n;
  logic [XLEN-1:0] hold_instr, hold_n;
  logic [XLEN-1:0] redir_pc, redir_n;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic            ifid_en;
  logic            ifid_flush;
  ifid_t           ifid_in;

  assign pc_plus4  = pc_f + XLEN'(4);
  assign target    = align_pc(redirect_target);
  assign imem_addr = pc_f;
  // HOLD already owns the returned word, so no request is outstanding there
  assign imem_req  = reset_n & (state_q != HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      pc_f       <= RESET_PC;
      hold_instr <= '0;
      redir_pc   <= '0;
    end else begin
      state_q    <= state_n;
      pc_f       <= pc_n;
      hold_instr <= hold_n;
      redir_pc   <= redir_n;
    end
  end

  always_comb begin
    state_n         = state_q;
    pc_n            = pc_f;
    hold_n          = hold_instr;
    redir_n         = redir_pc;
    ifid_en         = 1'b0;
    ifid_flush      = 1'b0;
    ifid_in.instr   = imem_rdata;
    ifid_in.pcplus4 = pc_plus4;

    unique case (state_q)
      RUN: begin
        if (redirect_valid && imem_ready) begin
          pc_n       = target;
          ifid_flush = 1'b1;
        end else if (redirect_valid) begin
          redir_n    = target;
          ifid_flush = 1'b1;
          state_n    = DRAIN;
        end else if (imem_ready && !stall_d) begin
          ifid_en = 1'b1;
          pc_n    = pc_plus4;
        end else if (imem_ready) begin
          hold_n  = imem_rdata;
          state_n = HOLD;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_n       = target;
          ifid_flush = 1'b1;
          state_n    = RUN;
        end else if (!stall_d) begin
          ifid_en       = 1'b1;
          ifid_in.instr = hold_instr;
          pc_n          = pc_plus4;
          state_n       = RUN;
        end
      end

      DRAIN: begin
        // Wrong-path word is dropped; the slot stays a bubble regardless of stall
        ifid_flush = 1'b1;
        if (redirect_valid) redir_n = target;
        if (imem_ready) begin
          pc_n    = redirect_valid ? target : redir_pc;
          state_n = RUN;
        end
      end

      default: state_n = RUN;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (ifid_en),
    .flush     (ifid_flush),
    .d         (ifid_in),
    .instr_d   (instr_d),
    .pcplus4_d (pcplus4_d),
    .valid_d   (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard on delivered IF/ID slots plus
// cycle-level checks of the fetch address, request and bubbles.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall_d;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;

  int n_checks = 0;
  int n_fail   = 0;
  ifid_t exp_q[$];

  always #5 clk = ~clk;

  // Memory returns address + 0x100
  assign imem_rdata = imem_addr + 32'h100;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .stall_d         (stall_d),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_d         (instr_d),
    .pcplus4_d       (pcplus4_d),
    .valid_d         (valid_d)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_slot(input logic [31:0] ins, input logic [31:0] pc4);
    ifid_t e;
    e.instr   = ins;
    e.pcplus4 = pc4;
    exp_q.push_back(e);
  endtask

  // Monitor: each newly presented valid IF/ID slot is popped and compared
  initial begin
    logic        last_v;
    logic [31:0] last_i, last_p;
    ifid_t       e;
    last_v = 1'b0;
    last_i = '0;
    last_p = '0;
    forever begin
      @(negedge clk);
      if (valid_d === 1'b1 && (!last_v || instr_d !== last_i || pcplus4_d !== last_p)) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got instr %h pc4 %h with nothing expected", instr_d, pcplus4_d);
        end else begin
          e = exp_q.pop_front();
          if (instr_d !== e.instr || pcplus4_d !== e.pcplus4) begin
            n_fail++;
            $display("FAIL sb_slot: got instr %h pc4 %h expected instr %h pc4 %h",
                     instr_d, pcplus4_d, e.instr, e.pcplus4);
          end
        end
      end
      last_v = (valid_d === 1'b1);
      last_i = instr_d;
      last_p = pcplus4_d;
    end
  end

  initial begin
    reset_n         = 1'b0;
    imem_ready      = 1'b1;
    stall_d         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;

    // Reset state
    tick();
    tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(valid_d), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr_d, 32'h0);
    check("rst_pc4", pcplus4_d, 32'h0);

    // 1: streaming fetch
    reset_n = 1'b1;
    #1;
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    expect_slot(32'h100, 32'h4);
    tick();
    check("t1_addr4", imem_addr, 32'h4);
    check("t1_valid", 32'(valid_d), 32'd1);
    expect_slot(32'h104, 32'h8);
    tick();
    check("t1_addr8", imem_addr, 32'h8);

    // 2: memory not ready for 3 cycles
    imem_ready = 1'b0;
    tick();
    tick();
    tick();
    check("t2_addr", imem_addr, 32'h8);
    check("t2_instr", instr_d, 32'h104);
    check("t2_pc4", pcplus4_d, 32'h8);
    imem_ready = 1'b1;
    expect_slot(32'h108, 32'hC);
    tick();
    check("t2_addrC", imem_addr, 32'hC);
    check("t2_instr_new", instr_d, 32'h108);

    // 3: stall while word at 0xC returns
    stall_d = 1'b1;
    tick();
    check("t3_req_hold", 32'(imem_req), 32'd0);
    check("t3_addr_hold", imem_addr, 32'hC);
    check("t3_instr_hold", instr_d, 32'h108);
    tick();
    check("t3_req_hold2", 32'(imem_req), 32'd0);
    check("t3_addr_hold2", imem_addr, 32'hC);
    stall_d = 1'b0;
    expect_slot(32'h10C, 32'h10);
    tick();
    check("t3_addr10", imem_addr, 32'h10);
    check("t3_instr", instr_d, 32'h10C);
    check("t3_pc4", pcplus4_d, 32'h10);
    check("t3_req", 32'(imem_req), 32'd1);

    // 4: redirect with ready, unaligned target
    expect_slot(32'h110, 32'h14);
    tick();
    check("t4_addr14", imem_addr, 32'h14);
    redirect_valid  = 1'b1;
    redirect_target = 32'h43;
    tick();
    check("t4_addr40", imem_addr, 32'h40);
    check("t4_valid", 32'(valid_d), 32'd0);
    check("t4_instr", instr_d, 32'h0);
    redirect_valid = 1'b0;
    expect_slot(32'h140, 32'h44);
    tick();
    check("t4_addr44", imem_addr, 32'h44);
    check("t4_pc4", pcplus4_d, 32'h44);

    // 5: redirect while waiting, second redirect in DRAIN wins
    redirect_valid  = 1'b1;
    redirect_target = 32'h10;
    tick();
    check("t5_addr10", imem_addr, 32'h10);
    imem_ready      = 1'b0;
    redirect_target = 32'h40;
    tick();
    check("t5_drain_addr_a", imem_addr, 32'h10);
    check("t5_drain_req", 32'(imem_req), 32'd1);
    check("t5_drain_valid_a", 32'(valid_d), 32'd0);
    redirect_valid = 1'b0;
    stall_d        = 1'b1;
    tick();
    check("t5_drain_addr_b", imem_addr, 32'h10);
    check("t5_drain_valid_b", 32'(valid_d), 32'd0);
    stall_d         = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h80;
    tick();
    check("t5_drain_addr_c", imem_addr, 32'h10);
    redirect_valid = 1'b0;
    imem_ready     = 1'b1;
    tick();
    check("t5_addr80", imem_addr, 32'h80);
    check("t5_valid_drop", 32'(valid_d), 32'd0);
    expect_slot(32'h180, 32'h84);
    tick();
    check("t5_addr84", imem_addr, 32'h84);
    check("t5_instr", instr_d, 32'h180);

    // 6: async reset in the middle of DRAIN
    imem_ready      = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    tick();
    check("t6_drain_addr", imem_addr, 32'h84);
    redirect_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_req", 32'(imem_req), 32'd0);
    check("t6_rst_valid", 32'(valid_d), 32'd0);
    check("t6_rst_addr", imem_addr, 32'h0);
    tick();
    reset_n    = 1'b1;
    imem_ready = 1'b1;
    #1;
    check("t6_restart_addr", imem_addr, 32'h0);
    check("t6_restart_req", 32'(imem_req), 32'd1);
    expect_slot(32'h100, 32'h4);
    tick();
    check("t6_addr4", imem_addr, 32'h4);
    expect_slot(32'h104, 32'h8);
    tick();
    check("t6_addr8", imem_addr, 32'h8);
    imem_ready = 1'b0;
    tick();
    tick();

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
